// File: rtl/joypad_conditioner_pkg.sv
// Shared constants for the joypad conditioner: button indices and the
// two-register map seen by the SoC bus.
package joypad_pkg;

    localparam int N_BUTTONS_DEFAULT = 5;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;

    localparam logic REG_LEVEL = 1'b0;
    localparam logic REG_EVENT = 1'b1;

    localparam int PRESS_LSB      = 0;
    localparam int RELEASE_LSB    = 8;
    localparam int REPEAT_CAP_BIT = 16;

endpackage

// File: rtl/joypad_conditioner_if.sv
// Register bus between the SoC address decode and the joypad conditioner.
interface joypad_bus_if;
    logic        addr;
    logic [31:0] wdata;
    logic        wenable;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output wenable, input rdata);
    modport slave  (input addr, input wdata, input wenable, output rdata);
endinterface

// File: rtl/joypad_conditioner_debounce_cell.sv
// One button: two-FF synchroniser, polarity normalisation and debounce
// counter. rise/fall are combinational and assert in the cycle before
// `level` changes, so the parent latches events on the same edge.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic IDLE_RAW = RAW_ACTIVE_LOW;

    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;
    logic          accept;

    // Synchroniser; reset loads the released pin level so no phantom press.
    always_ff @(posedge clk) begin
        if (rst) sync <= {2{IDLE_RAW}};
        else     sync <= {sync[0], raw};
    end

    assign s      = sync[1] ^ IDLE_RAW;
    assign accept = (s != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise   = accept & s;
    assign fall   = accept & ~s;

    // Debounce: count consecutive disagreeing cycles, any glitch restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (s == level) begin
            cnt <= '0;
        end else if (accept) begin
            level <= s;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/joypad_conditioner.sv
// Joypad conditioner: per-button debounce, press/release event latching,
// level/event registers and a press-pending interrupt.
// Optional auto-repeat of held buttons: define JOYPAD_REPEAT_EN.
module joypad_conditioner
    import joypad_pkg::*;
#(
    parameter int N_BUTTONS       = N_BUTTONS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit RAW_ACTIVE_LOW  = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] raw_buttons,
    output logic [N_BUTTONS-1:0] joypad,
    output logic                 irq,
    joypad_bus_if.slave          bus
);
    logic [N_BUTTONS-1:0] rise, fall, rep;
    logic [N_BUTTONS-1:0] press_pend, release_pend;
    logic [N_BUTTONS-1:0] press_next, release_next;
    logic [N_BUTTONS-1:0] clr_press, clr_release;
    logic [31:0]          rdata_c;
    logic                 unused_wdata;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_buttons[i]),
            .level(joypad[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

`ifdef JOYPAD_REPEAT_EN
    localparam int   RMAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   RW         = $clog2(RMAX + 1);
    localparam logic REPEAT_CAP = 1'b1;

    logic [N_BUTTONS-1:0][RW-1:0] hold_tmr;

    // Repeat fires when a held button's countdown reaches zero.
    always_comb begin
        rep = '0;
        for (int i = 0; i < N_BUTTONS; i++)
            rep[i] = joypad[i] && !fall[i] && (hold_tmr[i] == '0);
    end

    // Per-button hold countdown: DELAY after acceptance, then PERIOD.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_tmr <= '0;
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (rise[i])                    hold_tmr[i] <= RW'(REPEAT_DELAY - 1);
                else if (!joypad[i] || fall[i]) hold_tmr[i] <= '0;
                else if (rep[i])                hold_tmr[i] <= RW'(REPEAT_PERIOD - 1);
                else                            hold_tmr[i] <= hold_tmr[i] - 1'b1;
            end
        end
    end
`else
    localparam logic REPEAT_CAP = 1'b0;
    logic unused_repeat_cfg;

    assign rep               = '0;
    assign unused_repeat_cfg = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
`endif

    assign unused_wdata = ^bus.wdata;

    // Write-1-to-clear decode and set-wins event update.
    always_comb begin
        clr_press   = '0;
        clr_release = '0;
        if (bus.wenable && bus.addr == REG_EVENT) begin
            clr_press   = bus.wdata[PRESS_LSB   +: N_BUTTONS];
            clr_release = bus.wdata[RELEASE_LSB +: N_BUTTONS];
        end
        press_next   = (press_pend   & ~clr_press)   | rise | rep;
        release_next = (release_pend & ~clr_release) | fall;
    end

    // Event registers and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_pend   <= '0;
            release_pend <= '0;
            irq          <= 1'b0;
        end else begin
            press_pend   <= press_next;
            release_pend <= release_next;
            irq          <= |press_next;
        end
    end

    // Combinational read mux.
    always_comb begin
        rdata_c = '0;
        if (bus.addr == REG_EVENT) begin
            rdata_c[PRESS_LSB   +: N_BUTTONS] = press_pend;
            rdata_c[RELEASE_LSB +: N_BUTTONS] = release_pend;
            rdata_c[REPEAT_CAP_BIT]           = REPEAT_CAP;
        end else begin
            rdata_c[N_BUTTONS-1:0] = joypad;
        end
    end

    assign bus.rdata = rdata_c;
endmodule

// File: tb/tb_joypad_conditioner.sv
// Bench for joypad_conditioner: directed scenarios plus random pin/bus
// traffic, checked every cycle against a window-based reference model.
module tb_joypad_conditioner;
    import joypad_pkg::*;

    localparam int DC   = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int MASK = (1 << DC) - 1;
`ifdef JOYPAD_REPEAT_EN
    localparam logic CAP = 1'b1;
`else
    localparam logic CAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] raw = 5'h1f;
    logic [4:0] joypad;
    logic       irq;

    joypad_bus_if bus ();

    joypad_conditioner #(
        .N_BUTTONS(5), .DEBOUNCE_CYCLES(DC), .RAW_ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .raw_buttons(raw), .joypad(joypad), .irq(irq), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state.
    logic [4:0]  m_jp = '0, m_press = '0, m_rel = '0, q_new = 5'h1f, q_old = 5'h1f;
    logic        m_irq = 1'b0;
    int unsigned hist[5];
    int          hold[5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A button flips once the last DC synchronised samples all oppose its level.
    task automatic model_edge();
        logic [4:0]  s, rise, fall, rep;
        logic [31:0] clr;
        if (rst) begin
            m_jp = '0; m_press = '0; m_rel = '0; m_irq = 1'b0;
            q_new = 5'h1f; q_old = 5'h1f;
            for (int i = 0; i < 5; i++) begin hist[i] = 0; hold[i] = 0; end
        end else begin
            s = ~q_old;
            rise = '0; fall = '0; rep = '0;
            for (int i = 0; i < 5; i++) begin
                hist[i] = (hist[i] << 1) | 32'(s[i]);
                if (!m_jp[i] && (hist[i] & MASK) == MASK) rise[i] = 1'b1;
                if (m_jp[i] && (hist[i] & MASK) == 0)     fall[i] = 1'b1;
`ifdef JOYPAD_REPEAT_EN
                if (m_jp[i] && !fall[i]) begin
                    hold[i]++;
                    if (hold[i] == RD || (hold[i] > RD && (hold[i] - RD) % RP == 0)) rep[i] = 1'b1;
                end
`endif
                if (rise[i]) hold[i] = 0;
            end
            m_jp    = (m_jp | rise) & ~fall;
            clr     = (bus.wenable && bus.addr) ? bus.wdata : 32'h0;
            m_press = (m_press & ~clr[4:0]) | rise | rep;
            m_rel   = (m_rel & ~clr[12:8]) | fall;
            m_irq   = |m_press;
            q_old   = q_new;
            q_new   = raw;
        end
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [31:0] r = '0;
        if (bus.addr) begin
            r[4:0] = m_press; r[12:8] = m_rel; r[16] = CAP;
        end else begin
            r[4:0] = m_jp;
        end
        return r;
    endfunction

    // One clock: advance model on current inputs, then compare after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("joypad", 32'(joypad), 32'(m_jp));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("rdata", bus.rdata, exp_rdata());
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_all();
        raw = 5'h1f; bus.wenable = 1'b0;
        steps(10);
        bus.addr = 1'b1; bus.wdata = 32'h1f1f; bus.wenable = 1'b1;
        step();
        bus.wenable = 1'b0;
    endtask

    int ev[8];
    int n_ev;

    initial begin
        bus.addr = 1'b0; bus.wdata = '0; bus.wenable = 1'b0;
        // Reset with all pins released.
        steps(3);
        chk("rst_joypad", 32'(joypad), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_level_reg", bus.rdata, 32'h0);
        bus.addr = 1'b1; #1;
        chk("rst_event_reg", bus.rdata, {15'h0, CAP, 16'h0});
        bus.addr = 1'b0;
        rst = 1'b0;

        // Reset mid-count discards the partial debounce.
        raw = 5'h1e;
        steps(4);
        rst = 1'b1; step(); rst = 1'b0;
        steps(5);
        chk("rst_restart_early", 32'(joypad), 32'h0);
        step();
        chk("rst_restart_hit", 32'(joypad), 32'h1);
        clear_all();

        // Latency: raw edge to joypad is 2 + DC cycles.
        bus.addr = 1'b1;
        raw = 5'h0f;
        steps(5);
        chk("lat_early", 32'(joypad), 32'h0);
        step();
        chk("lat_joypad", 32'(joypad), 32'h10);
        chk("lat_event", bus.rdata, {15'h0, CAP, 16'h0010});
        step();
        chk("lat_irq", 32'(irq), 32'h1);
        clear_all();

        // Chatter every 2 cycles never gets accepted.
        bus.addr = 1'b1;
        for (int k = 0; k < 40; k++) begin
            raw = ((k / 2) % 2 == 0) ? 5'h0f : 5'h1f;
            step();
        end
        raw = 5'h1f;
        chk("chatter_joypad", 32'(joypad), 32'h0);
        chk("chatter_event", bus.rdata, {15'h0, CAP, 16'h0});
        chk("chatter_irq", 32'(irq), 32'h0);
        clear_all();

        // Two buttons together, partial then full clear.
        bus.addr = 1'b1;
        raw = 5'h1a;
        steps(7);
        chk("dual_event", bus.rdata, {15'h0, CAP, 16'h0005});
        bus.wdata = 32'h1; bus.wenable = 1'b1; step(); bus.wenable = 1'b0;
        chk("dual_clr1", bus.rdata, {15'h0, CAP, 16'h0004});
        chk("dual_irq_hold", 32'(irq), 32'h1);
        bus.wdata = 32'h4; bus.wenable = 1'b1; step(); bus.wenable = 1'b0;
        chk("dual_irq_drop", 32'(irq), 32'h0);

        // Release of button 0 coincides with clearing its release bit.
        raw = 5'h1b;
        steps(5);
        bus.wdata = 32'h100; bus.wenable = 1'b1; step(); bus.wenable = 1'b0;
        chk("setwins_level", 32'(joypad), 32'h4);
        chk("setwins_bit8", 32'(bus.rdata[8]), 32'h1);
        clear_all();

        // Held button 1: clear after every press event, log event cycles.
        bus.addr = 1'b1; bus.wdata = 32'h2;
        raw = 5'h1d;
        n_ev = 0;
        for (int k = 0; k < 45; k++) begin
            step();
            if (bus.rdata[1] && n_ev < 8) begin ev[n_ev] = cyc; n_ev++; end
            bus.wenable = bus.rdata[1];
        end
        bus.wenable = 1'b0;
`ifdef JOYPAD_REPEAT_EN
        chk("rep_count", 32'(n_ev), 32'd4);
        chk("rep_delay", 32'(ev[1] - ev[0]), 32'(RD));
        chk("rep_period1", 32'(ev[2] - ev[1]), 32'(RP));
        chk("rep_period2", 32'(ev[3] - ev[2]), 32'(RP));
`else
        chk("norep_count", 32'(n_ev), 32'd1);
`endif
        clear_all();

        // Random pin activity, bus traffic and occasional reset.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) raw = 5'($urandom);
            bus.addr    = 1'($urandom);
            bus.wdata   = $urandom;
            bus.wenable = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; bus.wenable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
